// File: rtl/dmem_arb_pkg.sv
// Shared types and lane constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        ILL  = 2'd3
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        size_e       size;
        logic        uns;
        logic [31:0] wdata;
        logic        port;
    } cmd_t;

    localparam logic [3:0] LANE_B0 = 4'b0001;
    localparam logic [3:0] LANE_B1 = 4'b0010;
    localparam logic [3:0] LANE_B2 = 4'b0100;
    localparam logic [3:0] LANE_B3 = 4'b1000;
    localparam logic [3:0] LANE_H0 = 4'b0011;
    localparam logic [3:0] LANE_H1 = 4'b1100;
    localparam logic [3:0] LANE_W  = 4'b1111;

endpackage

// File: rtl/dmem_lane_decode.sv
// Maps byte offset, size, direction and signedness to dmem lane codes.
module dmem_lane_decode
    import dmem_arb_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  size_e      size,
    input  logic       we,
    input  logic       uns,
    output logic [3:0] wmem,
    output logic [4:0] rmem,
    output logic       misaligned
);

    logic [3:0] lane;

    always_comb begin
        lane       = 4'b0000;
        misaligned = 1'b0;
        unique case (size)
            BYTE: begin
                unique case (addr_lo)
                    2'd0: lane = LANE_B0;
                    2'd1: lane = LANE_B1;
                    2'd2: lane = LANE_B2;
                    2'd3: lane = LANE_B3;
                endcase
            end
            HALF: begin
                lane       = addr_lo[1] ? LANE_H1 : LANE_H0;
                misaligned = addr_lo[0];
            end
            WORD: begin
                lane       = LANE_W;
                misaligned = |addr_lo;
            end
            ILL: misaligned = 1'b1;
        endcase

        wmem = 4'b0000;
        rmem = 5'b00000;
        if (!misaligned) begin
            if (we) begin
                wmem = lane;
            end else begin
                // Word loads carry no sign: extension is meaningless at full width.
                rmem = {~uns & (size != WORD), lane};
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter sequencing each access through one dmem ISSUE cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_size,
    input  logic        m0_unsigned,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_size,
    input  logic        m1_unsigned,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [3:0]  wmem,
    output logic [4:0]  rmem,
    output logic [31:0] mem_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);

    state_e      state_q, state_d;
    logic        last_q;
    cmd_t        cmd_q, cmd_d;
    logic [1:0]  rvalid_q, err_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        grant, win;
    logic        issue;
    logic [3:0]  dec_wmem;
    logic [4:0]  dec_rmem;
    logic        misaligned;
    logic [31:0] resp_data;
    logic        unused_addr_hi;

    assign issue          = (state_q == ISSUE);
    assign unused_addr_hi = ^cmd_q.addr[31:ADDR_W+2];

    always_comb begin
        win   = (m0_req & m1_req) ? ~last_q : m1_req;
        // Reset suppresses grants so a requester never sees an accept that is then lost.
        grant = (state_q == IDLE) & (m0_req | m1_req) & ~rst;

        cmd_d = cmd_q;
        if (grant) begin
            cmd_d.we    = win ? m1_we : m0_we;
            cmd_d.addr  = win ? m1_addr : m0_addr;
            cmd_d.size  = size_e'(win ? m1_size : m0_size);
            cmd_d.uns   = win ? m1_unsigned : m0_unsigned;
            cmd_d.wdata = win ? m1_wdata : m0_wdata;
            cmd_d.port  = win;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m0_gnt = grant & ~win;
    assign m1_gnt = grant & win;

    dmem_lane_decode u_lane_decode (
        .addr_lo    (cmd_q.addr[1:0]),
        .size       (cmd_q.size),
        .we         (cmd_q.we),
        .uns        (cmd_q.uns),
        .wmem       (dec_wmem),
        .rmem       (dec_rmem),
        .misaligned (misaligned)
    );

    always_comb begin
        wmem       = issue ? dec_wmem : 4'b0000;
        rmem       = issue ? dec_rmem : 5'b00000;
        mem_addr   = issue ? {{(32 - ADDR_W){1'b0}}, cmd_q.addr[ADDR_W+1:2]} : 32'h0;
        store_data = issue ? cmd_q.wdata : 32'h0;
        resp_data  = misaligned ? 32'h0 : load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cmd_q    <= '0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            if (grant) begin
                last_q <= win;
            end
            if (issue) begin
                rvalid_q[cmd_q.port] <= 1'b1;
                err_q[cmd_q.port]    <= misaligned;
                if (cmd_q.port) begin
                    rdata1_q <= resp_data;
                end else begin
                    rdata0_q <= resp_data;
                end
            end
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req, we, uns;
    logic [31:0] addr  [2];
    logic [1:0]  size  [2];
    logic [31:0] wdata [2];
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  wmem;
    logic [4:0]  rmem;
    logic [31:0] mem_addr, store_data, load_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_size(size[0]),
        .m0_unsigned(uns[0]), .m0_wdata(wdata[0]), .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]),
        .m0_rdata(rdata0), .m0_err(err[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_size(size[1]),
        .m1_unsigned(uns[1]), .m1_wdata(wdata[1]), .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]),
        .m1_rdata(rdata1), .m1_err(err[1]),
        .wmem(wmem), .rmem(rmem), .mem_addr(mem_addr), .store_data(store_data),
        .load_data(load_data)
    );

    // dmem stand-in: acts on the falling edge, lane-shifts stores, extracts/extends loads.
    logic [31:0] mem [1024];

    function automatic int lane_lo(logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] dmem_write(logic [31:0] w, logic [3:0] m, logic [31:0] d);
        logic [31:0] r;
        int lo;
        r  = w;
        lo = lane_lo(m);
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*(i-lo) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] dmem_read(logic [31:0] w, logic [4:0] code);
        logic [31:0] v, msk;
        int lo, n;
        lo  = lane_lo(code[3:0]);
        n   = $countones(code[3:0]);
        msk = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v   = (w >> (8 * lo)) & msk;
        if (code[4] && v[8*n-1]) v = v | ~msk;
        return v;
    endfunction

    always @(negedge clk) begin
        if (wmem != 4'b0000) mem[mem_addr[9:0]] <= dmem_write(mem[mem_addr[9:0]], wmem, store_data);
        load_data <= (rmem[3:0] != 4'b0000) ? dmem_read(mem[mem_addr[9:0]], rmem) : 32'h0;
    end

    // Reference model: whole transactions with arithmetic on sizes and offsets.
    logic [31:0] ref_mem [1024];
    bit          m_issue;
    int          m_last;
    logic [1:0]  m_rv, m_err;
    logic [31:0] m_rd [2];
    int          c_port;
    logic        c_we, c_uns;
    logic [31:0] c_addr, c_wdata;
    logic [1:0]  c_size;
    logic [1:0]  last_gnt, dut_gnt;

    function automatic bit f_mis(logic [31:0] a, logic [1:0] s);
        return (s == 2'd3) || ((a % (32'd1 << s)) != 32'd0);
    endfunction

    function automatic logic [3:0] f_lane(logic [31:0] a, logic [1:0] s);
        int nb;
        nb = 1 << s;
        return 4'(((1 << nb) - 1) << int'(a % 4));
    endfunction

    function automatic logic [31:0] f_extract(logic [31:0] w, logic [31:0] a, logic [1:0] s,
                                              logic u);
        logic [31:0] v, msk;
        int nbits;
        nbits = 8 << s;
        msk   = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        v     = (w >> (8 * int'(a % 4))) & msk;
        if (!u && v[nbits-1]) v = v | ~msk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: predict, compare every output, advance the model, cross the edge.
    task automatic cycle();
        int          win, idx, off, nb;
        bit          mis;
        logic [3:0]  lane, e_wmem;
        logic [4:0]  e_rmem;
        logic [31:0] e_maddr, e_sd;
        logic [1:0]  e_gnt;
        #1;
        e_gnt = 2'b00;
        win   = 0;
        if (!m_issue && !rst && req != 2'b00) begin
            win = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
            e_gnt[win] = 1'b1;
        end
        e_wmem = 4'b0; e_rmem = 5'b0; e_maddr = 32'h0; e_sd = 32'h0; mis = 1'b0;
        if (m_issue) begin
            mis     = f_mis(c_addr, c_size);
            e_maddr = (c_addr >> 2) % (32'd1 << ADDR_W);
            e_sd    = c_wdata;
            if (!mis) begin
                lane = f_lane(c_addr, c_size);
                if (c_we) e_wmem = lane;
                else e_rmem = {1'(c_size != 2'd2 && !c_uns), lane};
            end
        end
        chk("gnt", {30'b0, gnt}, {30'b0, e_gnt});
        chk("wmem", {28'b0, wmem}, {28'b0, e_wmem});
        chk("rmem", {27'b0, rmem}, {27'b0, e_rmem});
        chk("mem_addr", mem_addr, e_maddr);
        chk("store_data", store_data, e_sd);
        chk("rvalid", {30'b0, rvalid}, {30'b0, m_rv});
        chk("err", {30'b0, err}, {30'b0, m_err});
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
        dut_gnt  = gnt;
        last_gnt = e_gnt;

        idx = int'((c_addr >> 2) % 1024);
        if (m_issue && c_we && !mis) begin
            off = int'(c_addr % 4);
            nb  = 1 << c_size;
            for (int k = 0; k < nb; k++) ref_mem[idx][8*(off+k) +: 8] = c_wdata[8*k +: 8];
        end
        if (rst) begin
            m_issue = 1'b0; m_last = 1; m_rv = 2'b00; m_err = 2'b00;
            m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        end else begin
            m_rv  = 2'b00;
            m_err = 2'b00;
            if (m_issue) begin
                m_rv[c_port]  = 1'b1;
                m_err[c_port] = mis;
                m_rd[c_port]  = (mis || c_we) ? 32'h0 : f_extract(ref_mem[idx], c_addr, c_size, c_uns);
                m_issue = 1'b0;
            end else if (e_gnt != 2'b00) begin
                c_port = win; c_we = we[win]; c_addr = addr[win]; c_size = size[win];
                c_uns = uns[win]; c_wdata = wdata[win];
                m_last = win; m_issue = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int p, input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] d);
        we[p] = w; addr[p] = a; size[p] = s; uns[p] = u; wdata[p] = d;
    endtask

    // Single-master access with literal expectations for the ISSUE and response cycles.
    task automatic do_access(input int p, input logic w, input logic [31:0] a, input logic [1:0] s,
                             input logic u, input logic [31:0] d, input logic [3:0] x_wmem,
                             input logic [4:0] x_rmem, input logic [31:0] x_maddr,
                             input logic x_err, input bit chk_rd, input logic [31:0] x_rd);
        int n;
        set_cmd(p, w, a, s, u, d);
        req[p] = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!dut_gnt[p] && n < 20);
        chk("gnt_wait", {31'b0, dut_gnt[p]}, 32'd1);
        req[p] = 1'b0;
        #1;
        chk("lit_wmem", {28'b0, wmem}, {28'b0, x_wmem});
        chk("lit_rmem", {27'b0, rmem}, {27'b0, x_rmem});
        chk("lit_mem_addr", mem_addr, x_maddr);
        cycle();
        #1;
        chk("lit_rvalid", {31'b0, rvalid[p]}, 32'd1);
        chk("lit_err", {31'b0, err[p]}, {31'b0, x_err});
        if (chk_rd) chk("lit_rdata", (p == 0) ? rdata0 : rdata1, x_rd);
        cycle();
    endtask

    task automatic rand_cmd(input int p);
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        set_cmd(p, 1'($urandom_range(0, 1)), a, (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                1'($urandom_range(0, 1)), $urandom);
    endtask

    logic [1:0] cont_exp [8];

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            mem[i] <= w;
            ref_mem[i] = w;
        end
        req = 2'b00;
        for (int p = 0; p < 2; p++) set_cmd(p, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        m_issue = 1'b0; m_last = 1; m_rv = 2'b00; m_err = 2'b00; m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        c_port = 0; c_we = 1'b0; c_addr = 32'h0; c_size = 2'd0; c_uns = 1'b0; c_wdata = 32'h0;
        last_gnt = 2'b00; dut_gnt = 2'b00;
        cont_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        @(posedge clk);
        #1;
        chk("rst_gnt", {30'b0, gnt}, 32'd0);
        chk("rst_rvalid", {30'b0, rvalid}, 32'd0);
        chk("rst_err", {30'b0, err}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_lanes", {23'b0, wmem, rmem}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_store_data", store_data, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        do_access(0, 1, 32'h100, 2, 0, 32'hDEADBEEF, 4'b1111, 5'b00000, 32'h40, 0, 0, 0);
        do_access(0, 0, 32'h100, 2, 0, 32'h0, 4'b0000, 5'b01111, 32'h40, 0, 1, 32'hDEADBEEF);
        do_access(1, 1, 32'h200, 2, 0, 32'h80FF7F01, 4'b1111, 5'b00000, 32'h80, 0, 0, 0);
        do_access(1, 0, 32'h203, 0, 0, 32'h0, 4'b0000, 5'b11000, 32'h80, 0, 1, 32'hFFFFFF80);
        do_access(1, 0, 32'h202, 0, 1, 32'h0, 4'b0000, 5'b00100, 32'h80, 0, 1, 32'h000000FF);
        do_access(0, 1, 32'h204, 2, 0, 32'h80011234, 4'b1111, 5'b00000, 32'h81, 0, 0, 0);
        do_access(0, 0, 32'h206, 1, 0, 32'h0, 4'b0000, 5'b11100, 32'h81, 0, 1, 32'hFFFF8001);
        do_access(0, 0, 32'h102, 2, 0, 32'h0, 4'b0000, 5'b00000, 32'h40, 1, 1, 32'h0);
        do_access(0, 1, 32'h101, 1, 0, 32'hAAAA, 4'b0000, 5'b00000, 32'h40, 1, 1, 32'h0);
        do_access(0, 0, 32'h100, 2, 0, 32'h0, 4'b0000, 5'b01111, 32'h40, 0, 1, 32'hDEADBEEF);

        // Reset lands on the edge that would have accepted the m1 store.
        do_access(1, 1, 32'h300, 2, 0, 32'h0BADF00D, 4'b1111, 5'b00000, 32'hC0, 0, 0, 0);
        set_cmd(1, 1, 32'h300, 2, 0, 32'h12345678);
        req[1] = 1'b1;
        rst    = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_mid_wmem", {28'b0, wmem}, 32'd0);
        chk("rst_mid_rvalid1", {31'b0, rvalid[1]}, 32'd0);
        set_cmd(0, 0, 32'h300, 2, 0, 32'h0);
        req[0] = 1'b1;
        cycle();
        chk("tie_after_rst", {30'b0, dut_gnt}, 32'h1);
        req[0] = 1'b0;
        cycle();
        #1;
        chk("rst_readback", rdata0, 32'h0BADF00D);
        cycle();
        req[1] = 1'b0;
        cycle();
        cycle();

        // Both masters saturate the port; last grant went to m1.
        set_cmd(0, 0, 32'h100, 2, 0, 32'h0);
        set_cmd(1, 0, 32'h200, 2, 0, 32'h0);
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("cont_gnt%0d", i), {30'b0, dut_gnt}, {30'b0, cont_exp[i]});
        end
        req = 2'b00;
        cycle();
        cycle();
        chk("cont_rdata0", rdata0, 32'hDEADBEEF);
        chk("cont_rdata1", rdata1, 32'h80FF7F01);

        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && last_gnt[p]) begin
                    req[p] = 1'b0;
                    if ($urandom_range(0, 2) != 0) begin
                        rand_cmd(p);
                        req[p] = 1'b1;
                    end
                end else if (req[p]) begin
                    if ($urandom_range(0, 19) == 0) req[p] = 1'b0;
                end else if ($urandom_range(0, 1) == 0) begin
                    rand_cmd(p);
                    req[p] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        req = 2'b00;
        for (int n = 0; n < 3; n++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
